// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_pkg
//  Description : Shared types and defaults for the systolic result path.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_RES = 12;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    typedef logic [DEF_DATA_W-1:0] result_word_t;

endpackage
`default_nettype wire

// File: rtl/result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : result_buffer
//  Description : NUM_RES x DATA_W register array, parallel load, indexed read.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_buffer
    import systolic_pkg::*;
#(
    parameter int    DATA_W  = DEF_DATA_W,
    parameter int    NUM_RES = DEF_NUM_RES,
    localparam int   IDX_W   = $clog2(NUM_RES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [NUM_RES*DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_RES];
    logic [DATA_W-1:0] w_rd_data;

    // Snapshot every word of the flattened result bus in a single edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_RES; i++) begin
                r_mem[i] <= load_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read mux; an index beyond the last word returns zero rather than X.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_RES; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    assign rd_data = w_rd_data;

endmodule
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : result_drain
//  Description : Captures a batch of MAC results on en_y and streams them out
//                one word per beat over valid/ready, flagging dropped batches.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_drain
    import systolic_pkg::*;
#(
    parameter int    DATA_W  = DEF_DATA_W,
    parameter int    NUM_RES = DEF_NUM_RES,
    localparam int   IDX_W   = $clog2(NUM_RES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_y,
    input  logic [NUM_RES*DATA_W-1:0] mac_res,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clr_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RES - 1);

    drain_state_t       r_state;
    drain_state_t       w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               r_overrun;
    logic               w_overrun_next;
    logic               w_load;
    logic               w_valid;
    logic               w_is_last;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_valid   = (r_state == DRAIN);
    assign w_is_last = (r_idx == LAST_IDX);

    result_buffer #(
        .DATA_W  (DATA_W),
        .NUM_RES (NUM_RES)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .load_data (mac_res),
        .rd_idx    (r_idx),
        .rd_data   (w_rd_data)
    );

    // State, beat index and sticky overrun registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Next-state logic: capture, beat advance, back-to-back reload, overrun.
    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_load         = 1'b0;
        // Clear is applied first so that a same-cycle overrun overrides it.
        w_overrun_next = r_overrun & ~clr_overrun;

        case (r_state)
            IDLE: begin
                if (en_y) begin
                    w_load       = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && w_is_last) begin
                    // The last beat frees the buffer, so a coincident en_y
                    // is a legal back-to-back batch, not an overrun.
                    w_idx_next = '0;
                    if (en_y) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    if (out_ready) begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                    if (en_y) begin
                        w_overrun_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    assign out_valid = w_valid;
    assign busy      = w_valid;
    assign out_idx   = r_idx;
    assign out_last  = w_valid & w_is_last;
    assign out_data  = w_rd_data;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_drain
//  Description : Self-checking bench for result_drain: vector table, directed
//                corner sequences and random traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;
    import systolic_pkg::*;

    localparam int DATA_W  = 32;
    localparam int NUM_RES = 12;
    localparam int IDX_W   = $clog2(NUM_RES);
    localparam int BW      = NUM_RES * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              en_y;
    logic [BW-1:0]     mac_res;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              busy;
    logic              overrun;
    logic              clr_overrun;

    int vectors    = 0;
    int miscompares = 0;

    result_drain #(.DATA_W(DATA_W), .NUM_RES(NUM_RES)) dut (
        .clk         (clk),
        .reset       (reset),
        .en_y        (en_y),
        .mac_res     (mac_res),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    // Reference model: words still owed for the current batch, plus the flag.
    typedef struct {
        result_word_t d;
        int           idx;
    } beat_t;
    beat_t m_q[$];
    bit    m_ovr;

    typedef struct {
        bit           en;
        bit           rdy;
        bit           clr;
        result_word_t base;
        bit           e_valid;
        int           e_idx;
        result_word_t e_data;
        bit           e_last;
        bit           e_busy;
        bit           e_ovr;
    } vec_t;
    vec_t tbl[25];

    function automatic logic [BW-1:0] mk(input result_word_t base);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_RES; i++) r[i*DATA_W +: DATA_W] = base + 32'(i);
        return r;
    endfunction

    function automatic logic [BW-1:0] rnd_res();
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_RES; i++) r[i*DATA_W +: DATA_W] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        bit v;
        v = (m_q.size() > 0);
        chk("valid", 32'(out_valid), 32'(v));
        chk("busy", 32'(busy), 32'(v));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("last", 32'(out_last), 32'(v && m_q.size() == 1));
        if (v) begin
            chk("idx", 32'(out_idx), 32'(m_q[0].idx));
            chk("data", out_data, m_q[0].d);
        end else begin
            chk("idle_idx", 32'(out_idx), 32'd0);
        end
    endtask

    // Called at a negedge: apply inputs, advance the model over the next
    // rising edge, then compare against the model at the following negedge.
    task automatic drive(input bit en, input bit rdy, input bit clr, input logic [BW-1:0] res);
        bit v, fire, lastb;
        en_y = en; out_ready = rdy; clr_overrun = clr; mac_res = res;
        @(posedge clk);
        v     = (m_q.size() > 0);
        fire  = v && rdy;
        lastb = (m_q.size() == 1);
        if (fire) void'(m_q.pop_front());
        if (clr) m_ovr = 1'b0;
        if (en) begin
            if (!v || (fire && lastb)) begin
                for (int i = 0; i < NUM_RES; i++) m_q.push_back('{res[i*DATA_W +: DATA_W], i});
            end else begin
                m_ovr = 1'b1;
            end
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic drain_all();
        int n = 0;
        while (m_q.size() > 0 && n < 100) begin
            drive(0, 1, 0, rnd_res());
            n++;
        end
        chk("drain_timeout", 32'(m_q.size()), 32'd0);
    endtask

    initial begin
        // Table: full drain of batch A, back-to-back batch B, drain to idle.
        tbl[0] = '{1, 1, 0, 32'h100, 1, 0, 32'h100, 0, 1, 0};
        for (int r = 1; r <= 11; r++)
            tbl[r] = '{0, 1, 0, 32'hDEAD0000, 1, r, 32'h100 + 32'(r), (r == 11), 1, 0};
        tbl[12] = '{1, 1, 0, 32'h200, 1, 0, 32'h200, 0, 1, 0};
        for (int r = 13; r <= 23; r++)
            tbl[r] = '{0, 1, 0, 32'hDEAD0000, 1, r - 12, 32'h200 + 32'(r - 12), (r == 23), 1, 0};
        tbl[24] = '{0, 1, 0, 32'hDEAD0000, 0, 0, 32'h200, 0, 0, 0};

        reset = 1'b1; en_y = 0; out_ready = 0; clr_overrun = 0; mac_res = '0;
        m_ovr = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_data", out_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 25; r++) begin
            drive(tbl[r].en, tbl[r].rdy, tbl[r].clr, mk(tbl[r].base));
            chk("tbl_valid", 32'(out_valid), 32'(tbl[r].e_valid));
            chk("tbl_idx", 32'(out_idx), 32'(tbl[r].e_idx));
            chk("tbl_data", out_data, tbl[r].e_data);
            chk("tbl_last", 32'(out_last), 32'(tbl[r].e_last));
            chk("tbl_busy", 32'(busy), 32'(tbl[r].e_busy));
            chk("tbl_ovr", 32'(overrun), 32'(tbl[r].e_ovr));
        end

        // Back-pressure 1,0,0,1,... with mac_res changing every cycle.
        drive(1, 0, 0, mk(32'h100));
        for (int k = 0; k < 60 && m_q.size() > 0; k++)
            drive(0, (k % 3) == 0, 0, rnd_res());
        chk("bp_done", 32'(m_q.size()), 32'd0);

        // Overrun at index 5, drain unchanged, then clear.
        drive(1, 1, 0, mk(32'h100));
        repeat (5) drive(0, 1, 0, rnd_res());
        chk("ovr_pre_idx", 32'(out_idx), 32'd5);
        drive(1, 1, 0, mk(32'h300));
        chk("ovr_set", 32'(overrun), 32'd1);
        for (int k = 6; k <= 11; k++) begin
            chk("ovr_data", out_data, 32'h100 + 32'(k));
            drive(0, 1, 0, rnd_res());
        end
        chk("ovr_idle", 32'(out_valid), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        drive(0, 0, 1, rnd_res());
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Set wins over a same-cycle clear.
        drive(1, 1, 0, mk(32'h500));
        drive(1, 1, 1, mk(32'h600));
        chk("set_wins", 32'(overrun), 32'd1);
        drive(0, 1, 1, rnd_res());
        drain_all();

        // Asynchronous reset at index 7.
        drive(1, 1, 0, mk(32'h100));
        repeat (7) drive(0, 1, 0, rnd_res());
        chk("mr_pre_idx", 32'(out_idx), 32'd7);
        en_y = 0;
        reset = 1'b1;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_idx", 32'(out_idx), 32'd0);
        m_q.delete();
        m_ovr = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        drive(1, 1, 0, mk(32'h400));
        chk("mr_restart_data", out_data, 32'h400);
        chk("mr_restart_idx", 32'(out_idx), 32'd0);
        drain_all();

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0), rnd_res());
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
